// File: rtl/piece_plotter_if.sv
// Cell-request handshake plus VGA pixel-write bus for the piece plotter.
// master = request producer / observer, slave = the plotter itself.
interface piece_plotter_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_x;
  logic [2:0] req_y;
  logic [1:0] req_colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output req_valid, req_x, req_y, req_colour,
    input  req_ready, vga_x, vga_y, vga_colour, plot, busy, done
  );

  modport slave (
    input  req_valid, req_x, req_y, req_colour,
    output req_ready, vga_x, vga_y, vga_colour, plot, busy, done
  );
endinterface

// File: rtl/piece_plotter.sv
// Expands one board-cell draw request into a CELL x CELL raster of VGA pixel
// writes, one pixel per clock, followed by a single-cycle done pulse.
module piece_plotter #(
  parameter int unsigned CELL_LOG2    = 2,
  parameter logic [7:0]  X_OFFSET     = 8'd0,
  parameter logic [6:0]  Y_OFFSET     = 7'd0,
  parameter logic [2:0]  BOARD_COLOUR = 3'b010,
  parameter logic [2:0]  GRID_COLOUR  = 3'b100,
  parameter bit          GRID_EN      = 1'b1
) (
  input logic             clk,
  input logic             resetn,
  piece_plotter_if.slave  bus
);

  localparam int unsigned CW = CELL_LOG2;
  localparam logic [CW-1:0] CELL_MAX = '1;

  typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [7:0]    base_x_q, base_x_d;
  logic [6:0]    base_y_q, base_y_d;
  logic [2:0]    fill_q, fill_d;
  logic [7:0]    vga_x_q, vga_x_d;
  logic [6:0]    vga_y_q, vga_y_d;
  logic [2:0]    vga_colour_q, vga_colour_d;

  logic [2:0]    mapped;
  logic [7:0]    acc_x;
  logic [6:0]    acc_y;
  logic [CW-1:0] ncol, nrow;

  always_comb begin
    case (bus.req_colour)
      2'b11:   mapped = 3'b000;
      2'b10:   mapped = 3'b111;
      default: mapped = BOARD_COLOUR;
    endcase
  end

  // Cell origin in pixel space; wraps silently on overflow.
  assign acc_x = X_OFFSET + (8'(bus.req_x) << CELL_LOG2);
  assign acc_y = Y_OFFSET + (7'(bus.req_y) << CELL_LOG2);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    base_x_d     = base_x_q;
    base_y_d     = base_y_q;
    fill_d       = fill_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    ncol         = col_q + CW'(1);
    nrow         = (col_q == CELL_MAX) ? row_q + CW'(1) : row_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          state_d      = StDraw;
          col_d        = '0;
          row_d        = '0;
          base_x_d     = acc_x;
          base_y_d     = acc_y;
          fill_d       = mapped;
          vga_x_d      = acc_x;
          vga_y_d      = acc_y;
          vga_colour_d = GRID_EN ? GRID_COLOUR : mapped;
        end
      end
      StDraw: begin
        if (col_q == CELL_MAX && row_q == CELL_MAX) begin
          state_d = StDone;
        end else begin
          // Outputs are registered, so load the coordinates of the next pixel.
          col_d        = ncol;
          row_d        = nrow;
          vga_x_d      = base_x_q + 8'(ncol);
          vga_y_d      = base_y_q + 7'(nrow);
          vga_colour_d = (GRID_EN && (ncol == '0 || nrow == '0)) ? GRID_COLOUR : fill_q;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      base_x_q     <= '0;
      base_y_q     <= '0;
      fill_q       <= BOARD_COLOUR;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= BOARD_COLOUR;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      base_x_q     <= base_x_d;
      base_y_q     <= base_y_d;
      fill_q       <= fill_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
    end
  end

  // Status strobes decode straight from the state register.
  assign bus.req_ready  = (state_q == StIdle);
  assign bus.plot       = (state_q == StDraw);
  assign bus.busy       = (state_q == StDraw);
  assign bus.done       = (state_q == StDone);
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;

endmodule

// File: tb/tb_piece_plotter.sv
// Self-checking bench: two plotter instances (grid on / offset 0, grid off /
// x offset 250) driven with directed and random cell requests.
module tb_piece_plotter;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   t0, t1, tr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  piece_plotter_if ifa ();
  piece_plotter_if ifb ();

  piece_plotter u_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifa)
  );

  piece_plotter #(
    .X_OFFSET (8'd250),
    .GRID_EN  (1'b0)
  ) u_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] map_col(input logic [1:0] c);
    if (c == 2'b11) return 3'b000;
    if (c == 2'b10) return 3'b111;
    return 3'b010;
  endfunction

  // Reference pixel {x, y, colour} for pixel idx (raster order) of a cell.
  function automatic logic [17:0] exp_pixel(input bit sel, input int x, input int y,
                                            input logic [1:0] c, input int idx);
    int col = idx % 4;
    int row = idx / 4;
    int px  = ((sel ? 250 : 0) + x * 4 + col) % 256;
    int py  = (y * 4 + row) % 128;
    logic [2:0] colour;
    colour = (!sel && (col == 0 || row == 0)) ? 3'b100 : map_col(c);
    return {px[7:0], py[6:0], colour};
  endfunction

  task automatic get(input bit sel, output logic [7:0] vx, output logic [6:0] vy,
                     output logic [2:0] vc, output logic pl, output logic bs,
                     output logic dn, output logic rdy);
    if (sel) begin
      vx = ifb.vga_x; vy = ifb.vga_y; vc = ifb.vga_colour;
      pl = ifb.plot;  bs = ifb.busy;  dn = ifb.done; rdy = ifb.req_ready;
    end else begin
      vx = ifa.vga_x; vy = ifa.vga_y; vc = ifa.vga_colour;
      pl = ifa.plot;  bs = ifa.busy;  dn = ifa.done; rdy = ifa.req_ready;
    end
  endtask

  task automatic drv(input bit sel, input logic v, input logic [2:0] x, input logic [2:0] y,
                     input logic [1:0] c);
    if (sel) begin
      ifb.req_valid = v; ifb.req_x = x; ifb.req_y = y; ifb.req_colour = c;
    end else begin
      ifa.req_valid = v; ifa.req_x = x; ifa.req_y = y; ifa.req_colour = c;
    end
  endtask

  // Starts and ends at a negedge with the selected DUT idle.
  task automatic run_cell(input bit sel, input logic [2:0] x, input logic [2:0] y,
                          input logic [1:0] c, input bit hold, input logic [2:0] nx,
                          input logic [2:0] ny, input logic [1:0] nc, output int acc_cyc);
    logic [7:0] vx; logic [6:0] vy; logic [2:0] vc;
    logic pl, bs, dn, rdy;
    logic [17:0] e;
    string s;
    s = sel ? "b" : "a";
    acc_cyc = 0;
    e = '0;
    get(sel, vx, vy, vc, pl, bs, dn, rdy);
    check({s, "_ready_pre"}, rdy, 1);
    drv(sel, 1'b1, x, y, c);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) acc_cyc = cyc;
      get(sel, vx, vy, vc, pl, bs, dn, rdy);
      e = exp_pixel(sel, int'(x), int'(y), c, i);
      check($sformatf("%s_plot%0d", s, i), pl, 1);
      check($sformatf("%s_busy%0d", s, i), bs, 1);
      check($sformatf("%s_ready%0d", s, i), rdy, 0);
      check($sformatf("%s_done%0d", s, i), dn, 0);
      check($sformatf("%s_x%0d", s, i), vx, e[17:10]);
      check($sformatf("%s_y%0d", s, i), vy, e[9:3]);
      check($sformatf("%s_col%0d", s, i), vc, e[2:0]);
      // Inputs wiggle during the draw; none of it may be taken.
      if (hold) drv(sel, 1'b1, x, y, c);
      else drv(sel, 1'($urandom), 3'($urandom), 3'($urandom), 2'($urandom));
    end
    @(negedge clk);
    get(sel, vx, vy, vc, pl, bs, dn, rdy);
    check({s, "_done_pulse"}, dn, 1);
    check({s, "_done_plot"}, pl, 0);
    check({s, "_done_busy"}, bs, 0);
    check({s, "_done_ready"}, rdy, 0);
    if (hold) drv(sel, 1'b1, nx, ny, nc);
    else drv(sel, 1'b0, 3'd0, 3'd0, 2'd0);
    @(negedge clk);
    get(sel, vx, vy, vc, pl, bs, dn, rdy);
    check({s, "_idle_ready"}, rdy, 1);
    check({s, "_idle_done"}, dn, 0);
    check({s, "_idle_plot"}, pl, 0);
    check({s, "_idle_hold_x"}, vx, e[17:10]);
    check({s, "_idle_hold_col"}, vc, e[2:0]);
  endtask

  initial begin
    logic [7:0] vx; logic [6:0] vy; logic [2:0] vc;
    logic pl, bs, dn, rdy;
    drv(0, 1'b0, 3'd0, 3'd0, 2'd0);
    drv(1, 1'b0, 3'd0, 3'd0, 2'd0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      get(s[0], vx, vy, vc, pl, bs, dn, rdy);
      check("rst_ready", rdy, 1);
      check("rst_plot", pl, 0);
      check("rst_busy", bs, 0);
      check("rst_done", dn, 0);
      check("rst_x", vx, 0);
      check("rst_y", vy, 0);
      check("rst_colour", vc, 3'b010);
    end
    resetn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      get(0, vx, vy, vc, pl, bs, dn, rdy);
      check("idle_ready", rdy, 1);
      check("idle_plot", pl, 0);
      check("idle_busy", bs, 0);
      check("idle_colour", vc, 3'b010);
    end

    run_cell(0, 3'd2, 3'd1, 2'b11, 0, 3'd0, 3'd0, 2'd0, tr);

    // Back-to-back with req_valid held high.
    run_cell(0, 3'd3, 3'd5, 2'b10, 1, 3'd4, 3'd6, 2'b01, t0);
    run_cell(0, 3'd4, 3'd6, 2'b01, 0, 3'd0, 3'd0, 2'd0, t1);
    check("b2b_spacing", t1 - t0, 18);

    // Grid off, x offset 250: column 7 wraps to 22..25.
    run_cell(1, 3'd7, 3'd2, 2'b11, 0, 3'd0, 3'd0, 2'd0, tr);
    run_cell(1, 3'd7, 3'd0, 2'b00, 0, 3'd0, 3'd0, 2'd0, tr);

    repeat (6) run_cell(0, 3'($urandom), 3'($urandom), 2'($urandom), 0, 3'd0, 3'd0, 2'd0, tr);
    repeat (4) run_cell(1, 3'($urandom), 3'($urandom), 2'($urandom), 0, 3'd0, 3'd0, 2'd0, tr);

    // Reset asserted after the fifth plot cycle.
    drv(0, 1'b1, 3'd1, 3'd1, 2'b11);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      get(0, vx, vy, vc, pl, bs, dn, rdy);
      check($sformatf("pre_rst_plot%0d", k), pl, 1);
      drv(0, 1'b0, 3'd0, 3'd0, 2'd0);
    end
    resetn = 1'b0;
    #1;
    get(0, vx, vy, vc, pl, bs, dn, rdy);
    check("mid_rst_plot", pl, 0);
    check("mid_rst_busy", bs, 0);
    check("mid_rst_done", dn, 0);
    check("mid_rst_ready", rdy, 1);
    @(negedge clk);
    resetn = 1'b1;
    run_cell(0, 3'd5, 3'd3, 2'b10, 0, 3'd0, 3'd0, 2'd0, tr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piece_plotter.md
Name: piece_plotter

Overview:
- Pixel-side consumer of board-cell draw requests from the reversi game controller.
- Accepts one cell request (board x, board y, 2-bit cell state) over a valid/ready handshake.
- Expands the request into a CELL x CELL block of pixel writes on the VGA adapter interface (x, y, colour, plot), one pixel per clock.
- Sits between the game FSM / board RAM scanner and the VGA adapter. Signals completion with a one-cycle done pulse.

Parameters:
- CELL_LOG2, 2, log2 of cell edge in pixels (default cell is 4x4 = 16 pixels).
- X_OFFSET, 8'd0, pixel x of board origin.
- Y_OFFSET, 7'd0, pixel y of board origin.
- BOARD_COLOUR, 3'b010, fill for empty cells (green).
- GRID_COLOUR, 3'b100, colour of cell row 0 / column 0 grid pixels.
- GRID_EN, 1, 1 = draw grid line on row 0 and column 0 of each cell; 0 = no grid.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  cell request present
- req_ready  out  1  block can accept a request
- req_x  in  3  board column 0..7
- req_y  in  3  board row 0..7
- req_colour  in  2  cell state: 2'b11 black, 2'b10 white, 2'b00/2'b01 empty
- vga_x  out  8  pixel x to VGA adapter
- vga_y  out  7  pixel y to VGA adapter
- vga_colour  out  3  pixel colour (RGB)
- plot  out  1  pixel write strobe
- busy  out  1  high while a cell is being drawn
- done  out  1  one-cycle pulse after the last pixel of a cell

Behaviour:
- Reset (resetn low, asynchronous):
  - State = IDLE; req_ready = 1; busy = 0; done = 0; plot = 0.
  - vga_x = 0; vga_y = 0; vga_colour = BOARD_COLOUR; col/row counters = 0.
- States: IDLE, DRAW, DONE.
- IDLE:
  - req_ready = 1.
  - On the rising edge where req_valid & req_ready, latch req_x, req_y and the mapped colour; clear col and row; go to DRAW.
  - Inputs are ignored in every other state and cycle.
- Colour map, applied at accept:
  - 2'b11 -> 3'b000.
  - 2'b10 -> 3'b111.
  - 2'b00 and 2'b01 -> BOARD_COLOUR.
- DRAW, one pixel per cycle, all outputs registered:
  - plot = 1; busy = 1; req_ready = 0.
  - vga_x = X_OFFSET + (x << CELL_LOG2) + col, truncated to 8 bits.
  - vga_y = Y_OFFSET + (y << CELL_LOG2) + row, truncated to 7 bits. Wrap on overflow is permitted and not flagged.
  - vga_colour = GRID_COLOUR if GRID_EN and (col == 0 or row == 0); otherwise the latched colour.
  - Scan order is raster within the cell: col increments every cycle; on col == CELL-1, col wraps to 0 and row increments.
  - After the pixel with row == CELL-1 and col == CELL-1, go to DONE.
- Timing:
  - The first pixel (col 0, row 0) appears with plot = 1 in the cycle immediately after the accept edge.
  - Exactly CELL*CELL consecutive plot-high cycles per request; no gaps.
- DONE:
  - One cycle: done = 1, plot = 0, busy = 0, req_ready = 0.
  - Next state IDLE; req_ready = 1 in the following cycle.
  - Request-to-request minimum spacing is CELL*CELL + 2 cycles.
- req_valid held high continuously: a new request is accepted on the first IDLE cycle after DONE, using input values at that edge.
- Outputs in IDLE/DONE: plot = 0. vga_x, vga_y and vga_colour hold their last driven values (the adapter ignores them while plot = 0).
- Reset mid-DRAW: plot drops immediately (asynchronous); no done pulse; the partial cell is not resumed.
- No internal queueing: one request in flight at most.

Test Plan:
- Reset, then idle with req_valid = 0 -> req_ready = 1, plot = 0, busy = 0, vga_colour = 3'b010 indefinitely.
- Request x=2, y=1, colour=2'b11, GRID_EN=1, offsets 0:
  - 16 plot cycles starting the cycle after accept.
  - x sweeps 8..11 per row, y sweeps 4..7.
  - Pixels with x==8 or y==4 are 3'b100; the other 9 are 3'b000.
  - done pulses once, the cycle after the pixel at (11,7).
- Request colour=2'b10 then 2'b01 with req_valid held high:
  - First cell interior is 3'b111; second cell interior is 3'b010.
  - Second accept occurs exactly 18 cycles after the first.
- GRID_EN=0, X_OFFSET=8'd250, request x=7:
  - vga_x = (250+28+col) mod 256, i.e. 22..25.
  - All 16 pixels use the mapped colour.
- Assert resetn low after the 5th plot cycle:
  - plot, busy and done go to 0 asynchronously.
  - After release, req_ready = 1 and the next request draws a full 16 pixels from (col 0, row 0).
- Change req_x/req_y/req_colour during DRAW:
  - Output pixels are unaffected; changes are not accepted.
  - req_ready stays 0 until the cycle after done.
